// File: rtl/br_seq.sv
// Branch sequencer: walks br/brl through condition evaluation, optional link
// and a conditional PC load, keeping running branch and taken counts.
module br_seq #(
    parameter int w      = 32,
    parameter int op_msb = 31,
    parameter int op_lsb = 27,
    parameter logic [op_msb-op_lsb:0] BR_OP  = 5'd8,
    parameter logic [op_msb-op_lsb:0] BRL_OP = 5'd9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [w-1:0] IR,
    input  logic         con_out,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         rc_out,
    output logic         con_in,
    output logic         pc_out,
    output logic         ra_in,
    output logic         rb_out,
    output logic         pc_in,
    output logic         taken,
    output logic [15:0]  br_cnt,
    output logic [15:0]  tk_cnt
);

    localparam int OPW = op_msb - op_lsb + 1;

    typedef enum logic [2:0] {IDLE, EVAL, LINK, JUMP, FIN} state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic           err_q, err_d;
    logic           taken_q, taken_d;
    logic [15:0]    br_cnt_q, br_cnt_d;
    logic [15:0]    tk_cnt_q, tk_cnt_d;

    logic [OPW-1:0] op_in;
    logic           op_legal;
    logic           unused_ir;

    assign op_in     = IR[op_msb:op_lsb];
    assign op_legal  = (op_in == BR_OP) || (op_in == BRL_OP);
    assign unused_ir = ^IR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            err_q    <= 1'b0;
            taken_q  <= 1'b0;
            br_cnt_q <= 16'd0;
            tk_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            err_q    <= err_d;
            taken_q  <= taken_d;
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    // Counters and the taken flag only move on the JUMP exit, so an
    // illegal opcode or an aborted sequence never touches them.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        err_d    = err_q;
        taken_d  = taken_q;
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opcode_d = op_in;
                    if (op_legal) begin
                        state_d = EVAL;
                    end else begin
                        state_d = FIN;
                        err_d   = 1'b1;
                    end
                end
            end
            EVAL:    state_d = (opcode_q == BRL_OP) ? LINK : JUMP;
            LINK:    state_d = JUMP;
            JUMP: begin
                state_d  = FIN;
                taken_d  = con_out;
                br_cnt_d = (br_cnt_q == 16'hFFFF) ? br_cnt_q : br_cnt_q + 16'd1;
                if (con_out && (tk_cnt_q != 16'hFFFF)) begin
                    tk_cnt_d = tk_cnt_q + 16'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == FIN);
        err    = (state_q == FIN) && err_q;
        rc_out = (state_q == EVAL);
        con_in = (state_q == EVAL);
        pc_out = (state_q == LINK);
        ra_in  = (state_q == LINK);
        rb_out = (state_q == JUMP);
        pc_in  = (state_q == JUMP) && con_out;
        taken  = taken_q;
        br_cnt = br_cnt_q;
        tk_cnt = tk_cnt_q;
    end

endmodule

// File: tb/tb_br_seq.sv
// Self-checking bench for br_seq: a step-queue model predicts every cycle's
// outputs, and directed runs pin latencies and counter values by hand.
module tb_br_seq;

    logic        clk = 1'b0;
    logic        rst, start, con_out;
    logic [31:0] IR;
    logic        busy, done, err, rc_out, con_in, pc_out, ra_in, rb_out, pc_in, taken;
    logic [15:0] br_cnt, tk_cnt;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    // One entry per remaining busy cycle of the instruction in flight.
    typedef struct packed {
        logic rc, ci, po, ri, ro, jmp, dn, er;
    } step_t;

    localparam step_t EVAL_S = 8'b1100_0000;
    localparam step_t LINK_S = 8'b0011_0000;
    localparam step_t JUMP_S = 8'b0000_1100;
    localparam step_t FIN_S  = 8'b0000_0010;
    localparam step_t ERR_S  = 8'b0000_0011;

    step_t       q[$];
    logic        mTaken;
    logic [15:0] mBr, mTk;

    br_seq dut (
        .clk(clk), .rst(rst), .start(start), .IR(IR), .con_out(con_out),
        .busy(busy), .done(done), .err(err), .rc_out(rc_out), .con_in(con_in),
        .pc_out(pc_out), .ra_in(ra_in), .rb_out(rb_out), .pc_in(pc_in),
        .taken(taken), .br_cnt(br_cnt), .tk_cnt(tk_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin : model
        step_t s;
        if (rst) begin
            q.delete();
            mTaken = 1'b0;
            mBr    = 16'd0;
            mTk    = 16'd0;
        end else if (q.size() > 0) begin
            s = q.pop_front();
            if (s.jmp) begin
                mTaken = con_out;
                if (mBr != 16'hFFFF) mBr = mBr + 16'd1;
                if (con_out && mTk != 16'hFFFF) mTk = mTk + 16'd1;
            end
        end else if (start) begin
            case (IR[31:27])
                5'd8: begin
                    q.push_back(EVAL_S); q.push_back(JUMP_S); q.push_back(FIN_S);
                end
                5'd9: begin
                    q.push_back(EVAL_S); q.push_back(LINK_S);
                    q.push_back(JUMP_S); q.push_back(FIN_S);
                end
                default: q.push_back(ERR_S);
            endcase
        end
    end

    always @(negedge clk) begin : compare
        logic [8:0] expv, actv;
        step_t s;
        if (checking) begin
            if (q.size() == 0) begin
                expv = 9'd0;
            end else begin
                s    = q[0];
                expv = {1'b1, s.dn, s.er, s.rc, s.ci, s.po, s.ri, s.ro, s.jmp & con_out};
            end
            actv = {busy, done, err, rc_out, con_in, pc_out, ra_in, rb_out, pc_in};
            checkOutput("ctrl", 32'(actv), 32'(expv));
            checkOutput("taken", 32'(taken), 32'(mTaken));
            checkOutput("br_cnt", 32'(br_cnt), 32'(mBr));
            checkOutput("tk_cnt", 32'(tk_cnt), 32'(mTk));
        end
    end

    task automatic applyStimulus(input logic [31:0] ir, input logic c, input int expLat,
                                 input logic expErr, input string tag);
        int lat;
        IR      = ir;
        con_out = c;
        start   = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " err"}, 32'(err), 32'(expErr));
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; IR = 32'd0; con_out = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        checking = 1'b1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset br_cnt", 32'(br_cnt), 32'd0);

        applyStimulus(32'h4000_0001, 1'b1, 3, 1'b0, "br taken");
        checkOutput("brT taken", 32'(taken), 32'd1);
        checkOutput("brT br_cnt", 32'(br_cnt), 32'd1);
        checkOutput("brT tk_cnt", 32'(tk_cnt), 32'd1);

        applyStimulus(32'h4000_0000, 1'b0, 3, 1'b0, "br not taken");
        checkOutput("brNT taken", 32'(taken), 32'd0);
        checkOutput("brNT br_cnt", 32'(br_cnt), 32'd2);
        checkOutput("brNT tk_cnt", 32'(tk_cnt), 32'd1);

        applyStimulus(32'h4800_0001, 1'b1, 4, 1'b0, "brl taken");
        checkOutput("brlT br_cnt", 32'(br_cnt), 32'd3);
        checkOutput("brlT tk_cnt", 32'(tk_cnt), 32'd2);

        applyStimulus(32'h1800_0000, 1'b1, 1, 1'b1, "illegal");
        checkOutput("ill taken", 32'(taken), 32'd1);
        checkOutput("ill br_cnt", 32'(br_cnt), 32'd3);
        checkOutput("ill tk_cnt", 32'(tk_cnt), 32'd2);

        applyStimulus(32'h4800_0001, 1'b0, 4, 1'b0, "brl not taken");
        checkOutput("brlNT taken", 32'(taken), 32'd0);
        checkOutput("brlNT br_cnt", 32'(br_cnt), 32'd4);

        // Abort a brl while it sits in LINK.
        IR = 32'h4800_0001; con_out = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("abort ra_in before", 32'(ra_in), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort ra_in after", 32'(ra_in), 32'd0);
        checkOutput("abort br_cnt", 32'(br_cnt), 32'd0);
        repeat (6) tick();
        checkOutput("abort idle", 32'(busy), 32'd0);

        // start held high for eight edges: accepted at edges 0 and 4 only.
        IR = 32'h4000_0001; con_out = 1'b1; start = 1'b1;
        repeat (8) tick();
        start = 1'b0;
        repeat (6) tick();
        checkOutput("held br_cnt", 32'(br_cnt), 32'd2);
        checkOutput("held tk_cnt", 32'(tk_cnt), 32'd2);

        force dut.br_cnt_q = 16'hFFFE;
        mBr = 16'hFFFE;
        tick();
        release dut.br_cnt_q;
        tick();
        checkOutput("preload br_cnt", 32'(br_cnt), 32'h0000_FFFE);
        applyStimulus(32'h4000_0001, 1'b1, 3, 1'b0, "sat 1");
        checkOutput("sat1 br_cnt", 32'(br_cnt), 32'h0000_FFFF);
        checkOutput("sat1 tk_cnt", 32'(tk_cnt), 32'd3);
        applyStimulus(32'h4000_0001, 1'b1, 3, 1'b0, "sat 2");
        checkOutput("sat2 br_cnt", 32'(br_cnt), 32'h0000_FFFF);
        checkOutput("sat2 tk_cnt", 32'(tk_cnt), 32'd4);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/br_seq.md
BR_SEQ -- requirements
Module: br_seq

Interface
REQ-001 Parameter: w, default 32, data and IR width.
REQ-002 Parameter: op_msb, default 31, MSB of the opcode field in IR.
REQ-003 Parameter: op_lsb, default 27, LSB of the opcode field in IR.
REQ-004 Parameter: BR_OP, default 5'd8, opcode of br (conditional branch).
REQ-005 Parameter: BRL_OP, default 5'd9, opcode of brl (conditional branch with link).
REQ-006 Port: clk, input, 1, single clock; all state updates on posedge clk.
REQ-007 Port: rst, input, 1, synchronous active-high reset.
REQ-008 Port: start, input, 1, request to execute the instruction held in IR.
REQ-009 Port: IR, input, w, instruction word; sampled only when start is accepted.
REQ-010 Port: con_out, input, 1, registered condition result from the condition unit.
REQ-011 Port: busy, output, 1, high in every state except IDLE.
REQ-012 Port: done, output, 1, one-cycle completion pulse.
REQ-013 Port: err, output, 1, one-cycle pulse together with done when the opcode is not br/brl.
REQ-014 Port: rc_out, output, 1, gate R[rc] onto the bus.
REQ-015 Port: con_in, output, 1, load enable of the condition unit.
REQ-016 Port: pc_out, output, 1, gate PC onto the bus.
REQ-017 Port: ra_in, output, 1, load the link register R[ra] from the bus.
REQ-018 Port: rb_out, output, 1, gate R[rb] onto the bus.
REQ-019 Port: pc_in, output, 1, load PC from the bus.
REQ-020 Port: taken, output, 1, registered flag: the last completed branch was taken.
REQ-021 Port: br_cnt, output, 16, count of completed br/brl instructions.
REQ-022 Port: tk_cnt, output, 16, count of taken branches.

Function
REQ-023 FSM states SHALL be IDLE, EVAL, LINK, JUMP and FIN.
REQ-024 In IDLE, start=1 SHALL latch IR[op_msb:op_lsb] into an internal opcode register and move to EVAL when the opcode is BR_OP or BRL_OP, otherwise to FIN with the error flag set; start=0 SHALL hold IDLE.
REQ-025 start SHALL be ignored while busy=1; there is no queueing.
REQ-026 EVAL SHALL assert rc_out=1 and con_in=1 for exactly one cycle, then go to LINK if the opcode is BRL_OP, else to JUMP.
REQ-027 LINK SHALL assert pc_out=1 and ra_in=1 for one cycle regardless of con_out, then go to JUMP.
REQ-028 JUMP SHALL assert rb_out=1 and pc_in=con_out for one cycle, capture taken<=con_out, then go to FIN.
REQ-029 FIN SHALL assert done=1 (and err=1 if flagged) for one cycle, then return to IDLE, clearing the error flag.
REQ-030 Latency from the start edge to done high SHALL be 3 cycles for br, 4 cycles for brl, and 1 cycle for an illegal opcode.
REQ-031 Bus-drive strobes (rc_out, pc_out, rb_out) SHALL be mutually exclusive in every cycle; all strobes SHALL be 0 in IDLE and FIN.
REQ-032 Strobes SHALL decode from the state register only, except pc_in, which is additionally gated by con_out.
REQ-033 br_cnt SHALL increment by 1 on leaving JUMP; tk_cnt SHALL increment when leaving JUMP with con_out=1.
REQ-034 Both counters SHALL saturate at 16'hFFFF with no wrap.
REQ-035 An illegal opcode SHALL leave taken, br_cnt and tk_cnt unchanged.
REQ-036 start asserted in the FIN cycle SHALL be ignored; a new start is accepted in IDLE on the following cycle at the earliest.

Reset
REQ-037 rst=1 SHALL, at the next posedge and from any state (including mid-sequence), force IDLE and set busy, done, err, taken, every strobe, br_cnt and tk_cnt to 0.
REQ-038 rst SHALL take priority over start.
REQ-039 An aborted sequence SHALL produce no done pulse and no counter update.

Verification
REQ-040 br taken: IR=32'h4000_0001, start pulse, con_out=1 from EVAL+1 -> rc_out/con_in at cycle 1, rb_out and pc_in at cycle 2, done at cycle 3, taken=1, br_cnt=1, tk_cnt=1.
REQ-041 br not taken: IR=32'h4000_0000, con_out=0 -> pc_in stays 0 in JUMP, done at cycle 3, taken=0, br_cnt increments, tk_cnt unchanged.
REQ-042 brl: IR=32'h4800_0001, con_out=1 -> pc_out/ra_in at cycle 2, pc_in at cycle 3, done at cycle 4; repeat with con_out=0 -> ra_in still asserted at cycle 2, pc_in=0.
REQ-043 Illegal opcode: IR=32'h1800_0000 -> done=1 and err=1 at cycle 1, no strobes asserted, counters unchanged.
REQ-044 Reset mid-flight: rst=1 during LINK of a brl -> next cycle IDLE with all outputs 0 and no done; start held high through busy is accepted exactly once per sequence.
REQ-045 Saturation: preload or run until br_cnt=16'hFFFF, then one more taken br -> br_cnt stays 16'hFFFF and tk_cnt increments normally.
